// File: rtl/flash_pkg.sv
// Shared state encoding and command constants for the flash command sequencer.
package flash_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_U1    = 4'd1,
    ST_U2    = 4'd2,
    ST_PROG  = 4'd3,
    ST_E1    = 4'd4,
    ST_E2    = 4'd5,
    ST_E3    = 4'd6,
    ST_ERASE = 4'd7,
    ST_BUSY  = 4'd8
  } flash_state_e;

  localparam logic [7:0]  CMD_AA    = 8'hAA;
  localparam logic [7:0]  CMD_55    = 8'h55;
  localparam logic [7:0]  CMD_A0    = 8'hA0;
  localparam logic [7:0]  CMD_80    = 8'h80;
  localparam logic [7:0]  CMD_10    = 8'h10;
  localparam logic [7:0]  CMD_30    = 8'h30;
  localparam logic [7:0]  CMD_F0    = 8'hF0;
  localparam logic [10:0] ADDR_C555 = 11'h555;
  localparam logic [10:0] ADDR_C2AA = 11'h2AA;

  // A command word carries the command byte on both halves of the bus.
  function automatic logic cmd_is(input logic [15:0] data, input logic [7:0] cmd);
    return (data[15:8] == cmd) && (data[7:0] == cmd);
  endfunction

endpackage

// File: rtl/flash_busy_timer.sv
// 24-bit down-counter that times program/erase busy periods; done while it sits at zero.
module flash_busy_timer (
  input  logic        MB_CLK,
  input  logic        RESET,
  input  logic        i_load,
  input  logic [23:0] i_load_val,
  output logic [23:0] o_value,
  output logic        o_done
);

  logic [23:0] r_value;

  // Load on command, otherwise count down and hold at zero.
  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      r_value <= 24'd0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (r_value != 24'd0) begin
      r_value <= r_value - 24'd1;
    end else begin
      r_value <= r_value;
    end
  end

  assign o_value = r_value;
  assign o_done  = (r_value == 24'd0);

endmodule

// File: rtl/flash_cmd_sequencer.sv
// JEDEC-style unlock/command sequencer for a 68000 flash window with busy timing and DTACK wait states.
module flash_cmd_sequencer
  import flash_pkg::*;
#(
  parameter int unsigned PROG_CYCLES   = 512,
  parameter int unsigned SECTOR_CYCLES = 24'h6C3000,
  parameter int unsigned CHIP_CYCLES   = 24'hFFFFFF
) (
  input  logic        MB_CLK,
  input  logic        RESET,
  input  logic        CPU_AS,
  input  logic        RW,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        FLASH_SEL,
  input  logic [10:0] ADDRESS_LOW,
  input  logic [15:0] DATA,
  output logic        FLASH_DTACK,
  output logic        BUSY,
  output logic        SEQ_ERR,
  output logic [3:0]  STATE
);

  localparam logic [23:0] PROG_LD   = 24'(PROG_CYCLES);
  localparam logic [23:0] SECTOR_LD = 24'(SECTOR_CYCLES);
  localparam logic [23:0] CHIP_LD   = 24'(CHIP_CYCLES);

  flash_state_e r_state;
  flash_state_e w_next;
  logic         r_armed;
  logic         r_seq_err;
  logic [1:0]   r_dtk_cnt;
  logic         r_dtk_low;
  logic         w_wr_qual;
  logic         w_wr_evt;
  logic         w_err;
  logic         w_busy;
  logic         w_tmr_load;
  logic [23:0]  w_tmr_val;
  logic [23:0]  w_tmr_value;
  logic         w_tmr_done;
  logic         w_at_555;
  logic         w_at_2aa;
  logic         w_unused_tmr;

  flash_busy_timer u_timer (
    .MB_CLK     (MB_CLK),
    .RESET      (RESET),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_value    (w_tmr_value),
    .o_done     (w_tmr_done)
  );

  assign w_unused_tmr = ^w_tmr_value;
  assign w_busy    = (r_state == ST_BUSY);
  assign w_wr_qual = !CPU_AS && !RW && !UDS && !LDS && FLASH_SEL;
  assign w_wr_evt  = w_wr_qual && !r_armed;
  assign w_at_555  = (ADDRESS_LOW == ADDR_C555);
  assign w_at_2aa  = (ADDRESS_LOW == ADDR_C2AA);

  // Arm flag: one write event per address-strobe assertion.
  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      r_armed <= 1'b0;
    end else if (CPU_AS) begin
      r_armed <= 1'b0;
    end else if (w_wr_qual) begin
      r_armed <= 1'b1;
    end else begin
      r_armed <= r_armed;
    end
  end

  // State and error-pulse registers.
  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_seq_err <= w_err;
    end
  end

  // Next-state decode; F0 resets the sequence from any non-busy state.
  always_comb begin
    w_next     = r_state;
    w_err      = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = 24'd0;
    if (r_state == ST_BUSY) begin
      if (w_tmr_done) begin
        w_next = ST_IDLE;
      end else begin
        w_next = ST_BUSY;
      end
    end else if (w_wr_evt) begin
      if (cmd_is(DATA, CMD_F0)) begin
        w_next = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cmd_is(DATA, CMD_AA) && w_at_555) w_next = ST_U1;
            else                                  w_next = ST_IDLE;
          end
          ST_U1: begin
            if (cmd_is(DATA, CMD_55) && w_at_2aa) begin
              w_next = ST_U2;
            end else begin
              w_next = ST_IDLE;
              w_err  = 1'b1;
            end
          end
          ST_U2: begin
            if (cmd_is(DATA, CMD_A0) && w_at_555) begin
              w_next = ST_PROG;
            end else if (cmd_is(DATA, CMD_80) && w_at_555) begin
              w_next = ST_E1;
            end else begin
              w_next = ST_IDLE;
              w_err  = 1'b1;
            end
          end
          ST_E1: begin
            if (cmd_is(DATA, CMD_AA) && w_at_555) begin
              w_next = ST_E2;
            end else begin
              w_next = ST_IDLE;
              w_err  = 1'b1;
            end
          end
          ST_E2: begin
            if (cmd_is(DATA, CMD_55) && w_at_2aa) begin
              w_next = ST_E3;
            end else begin
              w_next = ST_IDLE;
              w_err  = 1'b1;
            end
          end
          ST_E3: begin
            if (cmd_is(DATA, CMD_10) && w_at_555) begin
              w_next     = ST_BUSY;
              w_tmr_load = 1'b1;
              w_tmr_val  = CHIP_LD;
            end else if (cmd_is(DATA, CMD_30)) begin
              w_next     = ST_BUSY;
              w_tmr_load = 1'b1;
              w_tmr_val  = SECTOR_LD;
            end else begin
              w_next = ST_IDLE;
              w_err  = 1'b1;
            end
          end
          ST_PROG: begin
            w_next     = ST_BUSY;
            w_tmr_load = 1'b1;
            w_tmr_val  = PROG_LD;
          end
          default: begin
            w_next = ST_IDLE;
          end
        endcase
      end
    end else begin
      w_next = r_state;
    end
  end

  // DTACK delay: acknowledge from the second edge of the cycle, held off while busy.
  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      r_dtk_cnt <= 2'd0;
      r_dtk_low <= 1'b0;
    end else if (CPU_AS || !FLASH_SEL) begin
      r_dtk_cnt <= 2'd0;
      r_dtk_low <= 1'b0;
    end else begin
      if (r_dtk_cnt != 2'd2) r_dtk_cnt <= r_dtk_cnt + 2'd1;
      else                   r_dtk_cnt <= r_dtk_cnt;
      if (r_dtk_cnt != 2'd0 && !w_busy) r_dtk_low <= 1'b1;
      else                              r_dtk_low <= r_dtk_low;
    end
  end

  assign FLASH_DTACK = CPU_AS || !FLASH_SEL || !r_dtk_low;
  assign BUSY        = w_busy;
  assign SEQ_ERR     = r_seq_err;
  assign STATE       = r_state;

endmodule

// File: doc/flash_cmd_sequencer.md
FLASH_CMD_SEQUENCER -- requirements
Module: flash_cmd_sequencer

Interface
REQ-001 Parameter PROG_CYCLES, default 512: MB_CLK cycles that BUSY is held after a word-program data write.
REQ-002 Parameter SECTOR_CYCLES, default 24'h6C3000: MB_CLK cycles that BUSY is held after a sector-erase confirm.
REQ-003 Parameter CHIP_CYCLES, default 24'hFFFFFF: MB_CLK cycles that BUSY is held after a chip-erase confirm.
REQ-004 MB_CLK  in  1  7 MHz motherboard clock; all state changes on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 CPU_AS  in  1  68000 address strobe, active-low.
REQ-007 RW  in  1  1 = read, 0 = write.
REQ-008 UDS, LDS  in  1 each  data strobes, active-low.
REQ-009 FLASH_SEL  in  1  flash window decoded, programming session active; high = selected.
REQ-010 ADDRESS_LOW  in  11  CPU A[11:1], the flash word address.
REQ-011 DATA  in  16  CPU data bus, write data.
REQ-012 FLASH_DTACK  out  1  active-low DTACK for flash-window cycles.
REQ-013 BUSY  out  1  program or erase in progress.
REQ-014 SEQ_ERR  out  1  one-cycle pulse when a command sequence is broken.
REQ-015 STATE  out  4  current state encoding, for debug.

Function
REQ-016 Write event: a rising edge with CPU_AS=0, RW=0, UDS=0, LDS=0 and FLASH_SEL=1; it SHALL be registered once per CPU_AS assertion, and the arm flag SHALL clear on the first edge with CPU_AS=1.
REQ-017 Command match: both DATA bytes equal the command byte and ADDRESS_LOW equals 11'h555 ("C555") or 11'h2AA ("C2AA") as stated.
REQ-018 States: IDLE, U1, U2, PROG, E1, E2, E3, ERASE, BUSY.
REQ-019 IDLE: AA@C555 -> U1.
REQ-020 U1: 55@C2AA -> U2.
REQ-021 U2: A0@C555 -> PROG; 80@C555 -> E1.
REQ-022 E1: AA@C555 -> E2.
REQ-023 E2: 55@C2AA -> E3.
REQ-024 E3: 10@C555 -> BUSY, timer loaded with CHIP_CYCLES; 30 at any address -> BUSY, timer loaded with SECTOR_CYCLES.
REQ-025 PROG: any write event -> BUSY, timer loaded with PROG_CYCLES.
REQ-026 A write event that fits no listed transition in U1, U2, E1, E2 or E3 SHALL return the FSM to IDLE and pulse SEQ_ERR.
REQ-027 A write of F0 at any address SHALL return the FSM to IDLE from any non-BUSY state, without pulsing SEQ_ERR.
REQ-028 In IDLE, an unmatched write SHALL be ignored, with no SEQ_ERR.
REQ-029 Read cycles and byte writes (UDS≠LDS) SHALL NOT change the FSM.
REQ-030 BUSY state: 24-bit timer decrements each cycle; at 0 -> IDLE on the next edge; write events are ignored; BUSY=1 exactly while in BUSY state.
REQ-031 Timer loaded with N SHALL make BUSY high for N+1 cycles.
REQ-032 FLASH_DTACK SHALL be 1 whenever CPU_AS=1 or FLASH_SEL=0 (combinational release).
REQ-033 Otherwise FLASH_DTACK SHALL go 0 on the second rising edge after CPU_AS fell, provided BUSY=0 at that edge.
REQ-034 If BUSY=1, FLASH_DTACK SHALL be held at 1, inserting wait states, and SHALL go 0 on the first edge after BUSY clears.
REQ-035 A write event on the same edge as the timer reaching 0 SHALL be ignored; the FSM goes to IDLE.

Reset
REQ-036 RESET=0 SHALL asynchronously force: state IDLE, timer 0, arm flag clear, BUSY=0, SEQ_ERR=0, STATE=IDLE code, internal DTACK counter 0, so FLASH_DTACK=1.
REQ-037 A reset during BUSY or mid-sequence SHALL abort the operation with no residual state.

Structure
REQ-038 State encoding and the command constants (AA, 55, A0, 80, 10, 30, F0, C555, C2AA) SHALL live in shared package flash_pkg.
REQ-039 The timer SHALL be sub-module flash_busy_timer: load, value and done outputs.

Verification
REQ-040 Program: AA@555, 55@2AA, A0@555, then 1234@0x100 (all words) -> BUSY=1 for 513 cycles, then IDLE; no SEQ_ERR.
REQ-041 Sector erase: AA, 55, 80, AA, 55 sequence, then 3030@0x4000 -> BUSY for SECTOR_CYCLES+1 cycles (bench overrides the parameter to 100).
REQ-042 Broken sequence: AA@555, then 55@0x123 -> SEQ_ERR pulse of 1 cycle, STATE=IDLE.
REQ-043 Wait states: a read of the flash window while BUSY has 20 cycles left -> FLASH_DTACK stays 1 until BUSY falls, goes 0 on the next edge, and goes 1 once CPU_AS rises.
REQ-044 Abort: RESET low for 1 cycle mid-chip-erase -> BUSY=0 immediately; a following AA@555 moves the FSM to U1.
REQ-045 Reset command: AA, 55, 80, then F0F0 -> IDLE, SEQ_ERR=0; a byte write with UDS=1 during U1 leaves the state unchanged.
